hwpe_stream_fifo_lvl: RTL and testbench
=======================================

Name: hwpe_stream_fifo_lvl

Overview:
- Next-generation single-clock HWPE-Stream FIFO: any depth ≥ 2, not just powers of two.
- Exposes an exact fill level and runtime-programmable almost-full/almost-empty thresholds.
- Optional fall-through mode removes the mandatory 1-cycle latency when the queue is empty.
- Sits between streamers and engine datapaths wherever backpressure decoupling needs watermark-driven control.

Parameters:
- DATA_WIDTH, 32, stream data width; STRB_WIDTH = (DATA_WIDTH+7)/8.
- FIFO_DEPTH, 8, number of entries, any integer ≥ 2.
- FALL_THROUGH, 0, 1 = push data visible on pop in the same cycle when empty.
- LVL_WIDTH, $clog2(FIFO_DEPTH+1), width of level and threshold signals (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear, same effect as reset
- thr_almost_full_i  in  LVL_WIDTH  almost-full watermark
- thr_almost_empty_i  in  LVL_WIDTH  almost-empty watermark
- level_o  out  LVL_WIDTH  current occupancy, 0..FIFO_DEPTH
- flags_o  out  flags_fifo_t  empty/full/almost_empty/almost_full
- stall_cnt_o  out  32  push-stall cycle counter (see Optional Feature)
- push_i  sink  hwpe_stream_intf_stream(DATA_WIDTH)  input stream
- pop_o  source  hwpe_stream_intf_stream(DATA_WIDTH)  output stream

Behaviour:
- Reset or clear_i: push/pop pointers = 0, level = 0, storage = 0, stall counter = 0.
  - Outputs after reset: level_o = 0, empty = 1, full = 0, pop_o.valid = 0, push_i.ready = 1, pop_o.data/strb = 0.
  - almost_empty = 1 (0 ≤ any threshold); almost_full = (thr_almost_full_i == 0).
- clear_i has priority over the handshakes in the same cycle. Reset mid-transfer discards all contents; no partial beat survives.
- push = push_i.valid & push_i.ready; pop = pop_o.valid & pop_o.ready. Both handshakes follow HWPE-Stream rules; valid never depends on ready.
- push_i.ready = (level != FIFO_DEPTH), purely from registered state. It has no combinational path from pop_o.ready, even when full with a pop pending.
- Pointers increment on their handshake and wrap from FIFO_DEPTH-1 to 0 by explicit compare (non-power-of-2 safe).
- level_d = level + push - pop.
  - Simultaneous push and pop leave the level unchanged.
  - Push is impossible when full; pop is impossible when empty.
- FALL_THROUGH = 0:
  - pop_o.valid = (level != 0); pop_o carries storage[pop_ptr].
  - Minimum latency is 1 cycle.
- FALL_THROUGH = 1 and level == 0:
  - pop_o.valid = push_i.valid; pop_o data/strb = push_i data/strb (combinational).
  - If pop_o.ready = 1: beat passes through; no write, pointers and level unchanged.
  - If pop_o.ready = 0: beat is written as a normal push and level becomes 1.
- FALL_THROUGH = 1 and level > 0: behaves as FALL_THROUGH = 0.
- pop_o.data and pop_o.strb are forced to 0 whenever pop_o.valid = 0.
- Flags are combinational from registered level and the current thresholds:
  - empty = (level == 0); full = (level == FIFO_DEPTH).
  - almost_full = (level ≥ thr_almost_full_i); almost_empty = (level ≤ thr_almost_empty_i).
  - Thresholds may change at any cycle; flags follow in the same cycle. Thresholds above FIFO_DEPTH are legal (almost_full then never asserts).
- Storage is flip-flop based, written at push_ptr on a push that is not a fall-through.

Optional Feature:
- Macro HWPE_STREAM_FIFO_STALL_CNT_EN.
- Defined: stall_cnt_o increments each cycle push_i.valid & !push_i.ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset/clear_i.
- Undefined: counter logic absent; stall_cnt_o tied to 0. The port exists in both builds.

Decomposition:
- hwpe_stream_package: reuse flags_fifo_t. Add localparam function fifo_lvl_width(depth) returning $clog2(depth+1).
- One sub-module, hwpe_stream_fifo_lvl_mem: FIFO_DEPTH × (DATA_WIDTH+STRB_WIDTH) register array with write enable/address, asynchronous read, reset and clear.

Test Plan:
- DEPTH=5, FT=0, 5 pushes without pop → level_o 1..5, full = 1 and push_i.ready = 0 after 5th; 6th valid held, not accepted; 5 pops return data in order, empty again.
- DEPTH=5, 12 push+pop same-cycle beats after 2 prefilled → level_o stays 2; pointers wrap 4→0 twice; data order preserved.
- FT=1, empty, push_i.valid = 1 with data 0xA5, pop_o.ready = 1 → pop_o.valid = 1 and data 0xA5 in the same cycle; level_o stays 0. Repeat with pop_o.ready = 0 → level_o = 1 next cycle.
- thr_af = 3, thr_ae = 1, fill 0→4 → almost_empty at levels 0–1, almost_full at 3–4. Change thr_af to 6 at level 4 → almost_full drops in the same cycle.
- Level 3, then clear_i = 1 together with push_i.valid = 1 → next cycle level_o = 0, empty = 1, pop_o.data = 0; pushed beat dropped. Repeat with rst_ni low mid-stream: same result, asynchronously.
- Stall counter (macro defined): hold push_i.valid = 1 for 7 cycles while full → stall_cnt_o = 7. Macro undefined → stall_cnt_o = 0.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// hwpe_stream_package
//   Shared types and helpers for the HWPE-Stream FIFO family.
//   - flags_fifo_t   : occupancy flags reported by the FIFOs
//   - fifo_lvl_width : bits needed to hold an occupancy of 0..depth
package hwpe_stream_package;

  typedef struct packed {
    logic almost_full;
    logic almost_empty;
    logic full;
    logic empty;
  } flags_fifo_t;

  // Level counts 0..depth inclusive, hence depth+1 distinct values.
  function automatic int unsigned fifo_lvl_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// hwpe_stream_intf_stream
//   HWPE-Stream valid/ready handshake bundle.
//   valid, data, strb : driven by the source
//   ready             : driven by the sink
//   A beat transfers on a cycle with valid & ready; valid never waits on ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = (DATA_WIDTH + 7) / 8
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_fifo_lvl_mem.sv
// hwpe_stream_fifo_lvl_mem
//   Flip-flop storage for hwpe_stream_fifo_lvl: FIFO_DEPTH entries of
//   {strb, data}, one synchronous write port, one asynchronous read port.
//   Ports:
//     clk_i, rst_ni  clock, asynchronous active-low reset (zeroes all entries)
//     clear_i        synchronous clear (zeroes all entries)
//     we_i, waddr_i, wdata_i  write port
//     raddr_i, rdata_o        combinational read port
module hwpe_stream_fifo_lvl_mem #(
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned STRB_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter  int unsigned FIFO_DEPTH  = 8,
  localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + STRB_WIDTH,
  localparam int unsigned ADDR_WIDTH  = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   we_i,
  input  logic [ADDR_WIDTH-1:0]  waddr_i,
  input  logic [ENTRY_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0]  raddr_i,
  output logic [ENTRY_WIDTH-1:0] rdata_o
);

  logic [ENTRY_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hwpe_stream_fifo_lvl.sv
// hwpe_stream_fifo_lvl
//   Single-clock HWPE-Stream FIFO of any depth >= 2 with an exact fill
//   level and runtime almost-full / almost-empty watermarks. With
//   FALL_THROUGH = 1 an empty FIFO forwards the incoming beat to the output
//   in the same cycle.
//   Ports:
//     clk_i, rst_ni        clock, asynchronous active-low reset
//     clear_i              synchronous clear, same effect as reset
//     thr_almost_full_i    almost_full  when level >= this value
//     thr_almost_empty_i   almost_empty when level <= this value
//     level_o              occupancy 0..FIFO_DEPTH
//     flags_o              empty / full / almost_empty / almost_full
//     stall_cnt_o          cycles with push_i.valid while full (saturating)
//     push_i               input stream (sink)
//     pop_o                output stream (source)
//   Build option:
//     HWPE_STREAM_FIFO_STALL_CNT_EN  when defined, stall_cnt_o is a live
//                                    counter; otherwise it is tied to 0.
module hwpe_stream_fifo_lvl
  import hwpe_stream_package::*;
#(
  parameter  int unsigned DATA_WIDTH   = 32,
  parameter  int unsigned FIFO_DEPTH   = 8,
  parameter  int unsigned FALL_THROUGH = 0,
  localparam int unsigned LVL_WIDTH    = fifo_lvl_width(FIFO_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [LVL_WIDTH-1:0] thr_almost_full_i,
  input  logic [LVL_WIDTH-1:0] thr_almost_empty_i,
  output logic [LVL_WIDTH-1:0] level_o,
  output flags_fifo_t          flags_o,
  output logic [31:0]          stall_cnt_o,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o
);

  localparam int unsigned STRB_WIDTH  = (DATA_WIDTH + 7) / 8;
  localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + STRB_WIDTH;
  localparam int unsigned ADDR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam logic [LVL_WIDTH-1:0]  LVL_FULL = LVL_WIDTH'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam bit FT_EN = (FALL_THROUGH != 0);

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  logic [LVL_WIDTH-1:0]   level_q, level_d;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic                   empty, full, ft_path;
  logic                   pop_valid, push_hs, pop_hs, ft_bypass;
  logic                   wr_en, rd_en;
  logic [ENTRY_WIDTH-1:0] wr_entry, rd_entry, pop_entry;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_FULL);

  // Fall-through path is only live while nothing is stored.
  assign ft_path = FT_EN & empty;

  // ready comes from registered state only: no path from pop_o.ready.
  assign push_i.ready = ~full;

  assign pop_valid   = ft_path ? push_i.valid : ~empty;
  assign pop_o.valid = pop_valid;

  assign push_hs = push_i.valid & ~full;
  assign pop_hs  = pop_valid & pop_o.ready;

  // A beat consumed straight through never touches storage or counters.
  assign ft_bypass = ft_path & pop_hs;
  assign wr_en     = push_hs & ~ft_bypass;
  assign rd_en     = pop_hs & ~ft_bypass;

  assign wr_entry  = {push_i.strb, push_i.data};
  assign pop_entry = !pop_valid ? '0 : (ft_path ? wr_entry : rd_entry);

  assign pop_o.data = pop_entry[DATA_WIDTH-1:0];
  assign pop_o.strb = pop_entry[ENTRY_WIDTH-1:DATA_WIDTH];

  assign level_d = level_q + LVL_WIDTH'(wr_en) - LVL_WIDTH'(rd_en);

  // Pointer / level state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      level_q <= level_d;
      if (wr_en) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (rd_en) rd_ptr_q <= next_ptr(rd_ptr_q);
    end
  end

  hwpe_stream_fifo_lvl_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) i_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign level_o              = level_q;
  assign flags_o.empty        = empty;
  assign flags_o.full         = full;
  assign flags_o.almost_full  = (level_q >= thr_almost_full_i);
  assign flags_o.almost_empty = (level_q <= thr_almost_empty_i);

`ifdef HWPE_STREAM_FIFO_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Stall counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (clear_i) begin
      stall_cnt_q <= '0;
    end else if (push_i.valid & full) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_stream_fifo_lvl.sv
module tb_hwpe_stream_fifo_lvl;
  import hwpe_stream_package::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned SW    = 2;
  localparam int unsigned EW    = DW + SW;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned LW    = 3;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          clear;
  logic [LW-1:0] thr_af, thr_ae;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_strb;
  logic          out_ready;

  logic [LW-1:0] level0, level1;
  flags_fifo_t   flags0, flags1;
  logic [31:0]   stall0, stall1;

  int checks = 0;
  int errors = 0;

  // Hand-computed flag table for thr_af = 3, thr_ae = 1 at levels 0..4.
  bit af_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  bit ae_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push0 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop0 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push1 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop1 ();

  assign push0.valid = in_valid;
  assign push0.data  = in_data;
  assign push0.strb  = in_strb;
  assign push1.valid = in_valid;
  assign push1.data  = in_data;
  assign push1.strb  = in_strb;
  assign pop0.ready  = out_ready;
  assign pop1.ready  = out_ready;

  hwpe_stream_fifo_lvl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FALL_THROUGH(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear),
    .thr_almost_full_i(thr_af), .thr_almost_empty_i(thr_ae),
    .level_o(level0), .flags_o(flags0), .stall_cnt_o(stall0),
    .push_i(push0), .pop_o(pop0)
  );

  hwpe_stream_fifo_lvl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FALL_THROUGH(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear),
    .thr_almost_full_i(thr_af), .thr_almost_empty_i(thr_ae),
    .level_o(level1), .flags_o(flags1), .stall_cnt_o(stall1),
    .push_i(push1), .pop_o(pop1)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each FIFO is a queue of {strb, data} plus a stall count.
  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];
  int unsigned   sc0 = 0;
  int unsigned   sc1 = 0;

  task automatic model_cycle(input int id, input bit ft,
                             input logic [LW-1:0] lvl, input flags_fifo_t fl,
                             input logic [31:0] sc, input logic pv,
                             input logic [DW-1:0] pd, input logic [SW-1:0] ps,
                             input logic pr);
    logic [EW-1:0] q[$];
    int unsigned   cnt;
    int unsigned   n;
    logic          e_pv, e_pr;
    logic [EW-1:0] e_ent;
    logic [31:0]   e_sc;
    bit            push, pop;
    string         tag;
    tag = $sformatf("dut%0d", id);
    if (id == 0) begin q = q0; cnt = sc0; end
    else begin q = q1; cnt = sc1; end
    if (!rst_ni) begin q.delete(); cnt = 0; end
    n    = q.size();
    e_pr = (n != DEPTH);
    if (ft && n == 0) begin
      e_pv  = in_valid;
      e_ent = {in_strb, in_data};
    end else begin
      e_pv  = (n != 0);
      e_ent = (n != 0) ? q[0] : '0;
    end
    if (!e_pv) e_ent = '0;
`ifdef HWPE_STREAM_FIFO_STALL_CNT_EN
    e_sc = cnt;
`else
    e_sc = 32'd0;
`endif
    cmp({tag, " level"},     32'(lvl), n);
    cmp({tag, " pop_valid"}, 32'(pv), 32'(e_pv));
    cmp({tag, " pop_data"},  32'(pd), 32'(e_ent[DW-1:0]));
    cmp({tag, " pop_strb"},  32'(ps), 32'(e_ent[EW-1:DW]));
    cmp({tag, " push_rdy"},  32'(pr), 32'(e_pr));
    cmp({tag, " empty"},     32'(fl.empty), 32'(n == 0));
    cmp({tag, " full"},      32'(fl.full), 32'(n == DEPTH));
    cmp({tag, " alm_full"},  32'(fl.almost_full), 32'(n >= 32'(thr_af)));
    cmp({tag, " alm_empty"}, 32'(fl.almost_empty), 32'(n <= 32'(thr_ae)));
    cmp({tag, " stall_cnt"}, sc, e_sc);
    // Advance to the state after the coming rising edge.
    if (!rst_ni || clear) begin
      q.delete();
      cnt = 0;
    end else begin
      if (in_valid && !e_pr && cnt != 32'hFFFF_FFFF) cnt++;
      push = in_valid && e_pr;
      pop  = e_pv && out_ready;
      if (!(ft && n == 0 && push && pop)) begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back({in_strb, in_data});
      end
    end
    if (id == 0) begin q0 = q; sc0 = cnt; end
    else begin q1 = q; sc1 = cnt; end
  endtask

  always @(negedge clk) begin
    model_cycle(0, 1'b0, level0, flags0, stall0, pop0.valid, pop0.data, pop0.strb, push0.ready);
    model_cycle(1, 1'b1, level1, flags1, stall1, pop1.valid, pop1.data, pop1.strb, push1.ready);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    in_strb   = 2'b11;
    out_ready = r;
  endtask

  initial begin
    rst_ni = 1'b0;
    clear  = 1'b0;
    thr_af = 3'd4;
    thr_ae = 3'd1;
    drive(1'b0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    cmp("rst level",     32'(level0), 32'd0);
    cmp("rst empty",     32'(flags0.empty), 32'd1);
    cmp("rst full",      32'(flags0.full), 32'd0);
    cmp("rst pop_valid", 32'(pop0.valid), 32'd0);
    cmp("rst push_rdy",  32'(push0.ready), 32'd1);
    cmp("rst pop_data",  32'(pop0.data), 32'd0);
    cmp("rst alm_empty", 32'(flags0.almost_empty), 32'd1);
    cmp("rst alm_full",  32'(flags0.almost_full), 32'd0);
    rst_ni = 1'b1;

    // Fill to full, one extra beat held off, then drain in order
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'(i), 1'b0);
      step();
      cmp("fill level", 32'(level0), 32'(i));
    end
    cmp("fill full", 32'(flags0.full), 32'd1);
    cmp("fill push_rdy", 32'(push0.ready), 32'd0);
    drive(1'b1, 16'h6, 1'b0);
    step();
    cmp("held level", 32'(level0), 32'd5);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 16'h0, 1'b1);
      #1;
      cmp("drain data", 32'(pop0.data), 32'(i));
      step();
    end
    cmp("drain empty", 32'(flags0.empty), 32'd1);

    // Prefill 2, then 12 simultaneous push+pop beats (pointers wrap twice)
    drive(1'b1, 16'h100, 1'b0); step();
    drive(1'b1, 16'h101, 1'b0); step();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 16'(32'h102 + k), 1'b1);
      #1;
      cmp("pp data", 32'(pop0.data), 32'h100 + 32'(k));
      step();
      cmp("pp level", 32'(level0), 32'd2);
    end
    drive(1'b0, 16'h0, 1'b1);
    step(); step();

    // Fall-through on empty
    drive(1'b1, 16'hA5, 1'b1);
    #1;
    cmp("ft valid", 32'(pop1.valid), 32'd1);
    cmp("ft data", 32'(pop1.data), 32'hA5);
    cmp("nft valid", 32'(pop0.valid), 32'd0);
    cmp("nft data", 32'(pop0.data), 32'd0);
    step();
    cmp("ft level", 32'(level1), 32'd0);
    cmp("nft level", 32'(level0), 32'd1);
    drive(1'b0, 16'h0, 1'b1);
    step();
    drive(1'b1, 16'hA5, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0);
    #1;
    cmp("ft stored level", 32'(level1), 32'd1);
    cmp("ft stored data", 32'(pop1.data), 32'hA5);
    drive(1'b0, 16'h0, 1'b1);
    step();

    // Watermarks
    thr_af = 3'd3;
    thr_ae = 3'd1;
    drive(1'b0, 16'h0, 1'b0);
    #1;
    cmp("wm af l0", 32'(flags0.almost_full), 32'(af_tab[0]));
    cmp("wm ae l0", 32'(flags0.almost_empty), 32'(ae_tab[0]));
    for (int l = 1; l <= 4; l++) begin
      drive(1'b1, 16'(32'h200 + l), 1'b0);
      step();
      cmp("wm af", 32'(flags0.almost_full), 32'(af_tab[l]));
      cmp("wm ae", 32'(flags0.almost_empty), 32'(ae_tab[l]));
    end
    drive(1'b0, 16'h0, 1'b0);
    thr_af = 3'd6;
    #1;
    cmp("wm af thr6", 32'(flags0.almost_full), 32'd0);

    // Clear with a concurrent push at level 3
    drive(1'b0, 16'h0, 1'b1);
    step();
    cmp("pre-clear level", 32'(level0), 32'd3);
    drive(1'b1, 16'h77, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b0, 16'h0, 1'b0);
    #1;
    cmp("clear level", 32'(level0), 32'd0);
    cmp("clear empty", 32'(flags0.empty), 32'd1);
    cmp("clear pop_data", 32'(pop0.data), 32'd0);
    cmp("clear level ft", 32'(level1), 32'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(32'h300 + i), 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    cmp("arst level", 32'(level0), 32'd0);
    cmp("arst empty", 32'(flags0.empty), 32'd1);
    cmp("arst pop_valid", 32'(pop0.valid), 32'd0);
    cmp("arst pop_data", 32'(pop0.data), 32'd0);
    cmp("arst level ft", 32'(level1), 32'd0);
    step();
    rst_ni = 1'b1;

    // Stall counter: fill, then 7 cycles of valid while full
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 16'(32'h400 + i), 1'b0);
      step();
    end
`ifdef HWPE_STREAM_FIFO_STALL_CNT_EN
    cmp("stall cnt", stall0, 32'd7);
    cmp("stall cnt ft", stall1, 32'd7);
`else
    cmp("stall cnt", stall0, 32'd0);
    cmp("stall cnt ft", stall1, 32'd0);
`endif
    drive(1'b0, 16'h0, 1'b1);
    repeat (5) step();

    // Randomized traffic, phases biased toward fill, drain and mixed
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(3) != 0);
      in_data  = 16'($urandom);
      in_strb  = 2'($urandom);
      case ((c / 300) % 3)
        0:       out_ready = ($urandom_range(3) == 0);
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = $urandom_range(1) != 0;
      endcase
      clear = ($urandom_range(99) == 0);
      if (c % 37 == 0) begin
        thr_af = 3'($urandom);
        thr_ae = 3'($urandom);
      end
      step();
    end
    clear = 1'b0;
    drive(1'b0, 16'h0, 1'b1);
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
